// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are answered combinationally; a miss issues one word read and fills the frame.
module icache #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      missaddr_q, missaddr_d;
    logic [NSETS-1:0] valid_q;
    logic [TAGW-1:0]  tag_q [NSETS];
    logic [31:0]      data_q [NSETS];

    logic [IDXW-1:0]  req_idx, fill_idx;
    logic [TAGW-1:0]  req_tag, fill_tag;
    logic             lookup_hit;
    logic             fill;

    assign req_idx    = imemaddr[IDXW+1:2];
    assign req_tag    = imemaddr[31:IDXW+2];
    assign fill_idx   = missaddr_q[IDXW+1:2];
    assign fill_tag   = missaddr_q[31:IDXW+2];
    assign lookup_hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d    = state_q;
        missaddr_d = missaddr_q;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_hit) begin
                    ihit     = 1'b1;
                    imemload = data_q[req_idx];
                end else if (imemREN) begin
                    missaddr_d = imemaddr & 32'hFFFF_FFFC;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // Fetch address is frozen here; redirects are only seen after the fill.
                iREN  = 1'b1;
                iaddr = missaddr_q;
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            missaddr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            missaddr_q <= missaddr_d;
            if (fill) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data need no reset: valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: a driver issues fetches and pushes the
// expected hits/miss addresses; a monitor pops and compares on every DUT output event.
module tb_icache;
    localparam int NSETS = 16;
    localparam int IDXW  = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;

    icache #(.NSETS(NSETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        hit_q[$];
    logic [31:0] miss_q[$];
    int          total = 0;
    int          bad = 0;
    int          fixed_wait = -1;

    // Reference model: which word address each frame currently holds.
    logic        m_valid [NSETS];
    logic [31:0] m_word  [NSETS];

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        if (w == 32'h40) return 32'h2108000A;
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % NSETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_word[idx_of(a)] == (a & 32'hFFFF_FFFC));
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        m_valid[idx_of(a)] = 1'b1;
        m_word[idx_of(a)]  = a & 32'hFFFF_FFFC;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    endfunction

    // Memory responder: random (or forced) number of iwait=1 cycles, then one data cycle.
    int wait_left = -1;
    always @(posedge CLK) begin
        #1;
        if (iREN) begin
            if (wait_left < 0) wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            if (wait_left > 0) begin
                iwait = 1'b1;
                iload = $urandom;
                wait_left--;
            end else begin
                iwait = 1'b0;
                iload = mem_word(iaddr);
                wait_left = -1;
            end
        end else begin
            iwait = 1'b1;
            iload = $urandom;
            wait_left = -1;
        end
    end

    // Monitor: consumes expected hits and miss addresses as the DUT presents them.
    logic        iren_prev = 1'b0;
    logic [31:0] cur_miss = '0;
    always @(negedge CLK) begin
        if (!nRST) begin
            iren_prev = 1'b0;
        end else begin
            if (ihit) begin
                if (hit_q.size() == 0) begin
                    chk("spurious_hit", {31'd0, ihit}, 32'd0);
                end else begin
                    exp_t e;
                    e = hit_q.pop_front();
                    chk("hit_addr", imemaddr & 32'hFFFF_FFFC, e.addr);
                    chk("hit_data", imemload, e.data);
                end
                chk("iren_during_hit", {31'd0, iREN}, 32'd0);
            end
            if (iREN && !iren_prev) begin
                if (miss_q.size() == 0) begin
                    chk("spurious_iren", {31'd0, iREN}, 32'd0);
                    cur_miss = iaddr;
                end else begin
                    cur_miss = miss_q.pop_front();
                    chk("miss_iaddr", iaddr, cur_miss);
                end
            end else if (iREN) begin
                chk("iaddr_held", iaddr, cur_miss);
            end else begin
                chk("iaddr_idle", iaddr, 32'd0);
            end
            iren_prev = iREN;
        end
    end

    task automatic access(input logic [31:0] a);
        bit exp_hit;
        bit seen;
        int n;
        exp_t e;
        exp_hit = model_hit(a);
        e.addr  = a & 32'hFFFF_FFFC;
        e.data  = mem_word(e.addr);
        hit_q.push_back(e);
        if (!exp_hit) miss_q.push_back(e.addr);
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        seen = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (ihit) begin
                seen = 1;
                break;
            end
            n++;
        end
        chk("access_completes", {31'd0, seen}, 32'd1);
        if (exp_hit) chk("hit_latency", n, 0);
        else if (fixed_wait >= 0) chk("miss_latency", n, fixed_wait + 2);
        else chk("miss_not_instant", {31'd0, (n >= 2)}, 32'd1);
        model_fill(a);
        @(posedge CLK); #1;
        imemREN = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] a, input logic [31:0] b);
        bit done;
        miss_q.push_back(a & 32'hFFFF_FFFC);
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        @(negedge CLK);
        chk("redirect_no_hit", {31'd0, ihit}, 32'd0);
        @(posedge CLK); #1;
        imemREN  = 1'b0;
        imemaddr = b;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!iREN) begin
                done = 1;
                break;
            end
        end
        chk("redirect_completes", {31'd0, done}, 32'd1);
        model_fill(a);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            imemREN  = 1'b0;
            imemaddr = $urandom;
            @(negedge CLK);
            chk("idle_no_hit", {31'd0, ihit}, 32'd0);
            chk("idle_no_iren", {31'd0, iREN}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        model_reset();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        imemREN = 1'b0;
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;

        fixed_wait = 3;
        access(32'h40);
        fixed_wait = -1;
        access(32'h43);
        access(32'h440);
        access(32'h440);
        access(32'h40);

        redirect(32'h80, 32'hC0);
        access(32'h80);
        access(32'hC0);

        idle_cycles(10);
        access(32'h41);

        // Abort a fetch with reset while the read is outstanding.
        fixed_wait = 5;
        miss_q.push_back(32'h100);
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = 32'h100;
        @(negedge CLK);
        @(negedge CLK);
        chk("fetch_iren_before_rst", {31'd0, iREN}, 32'd1);
        @(posedge CLK); #3;
        nRST = 1'b0;
        #1;
        chk("async_rst_iren", {31'd0, iREN}, 32'd0);
        chk("async_rst_ihit", {31'd0, ihit}, 32'd0);
        chk("async_rst_iaddr", iaddr, 32'd0);
        imemREN = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;
        fixed_wait = -1;
        access(32'h40);

        for (int k = 0; k < 150; k++) begin
            a = ($urandom_range(0, 3) << (IDXW + 2)) | ($urandom_range(0, NSETS - 1) << 2)
                | $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: idle_cycles(int'($urandom_range(1, 3)));
                1: begin
                    b = $urandom;
                    if (model_hit(a)) access(a);
                    else redirect(a, b);
                end
                default: access(a);
            endcase
        end

        repeat (3) @(negedge CLK);
        chk("hit_q_drained", hit_q.size(), 0);
        chk("miss_q_drained", miss_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
